// File: rtl/glitcher_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e             : receiver FSM state encoding (3 bits)
//   UART_CLKS_PER_BIT_100M : sys_clk cycles per bit at 115200 baud from 100 MHz
//   DEFAULT_RX_FIFO_DEPTH  : default output FIFO depth when the FIFO build is used
package glitcher_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StStop     = 3'd3,
        StWaitIdle = 3'd4
    } rx_state_e;

    localparam int unsigned UART_CLKS_PER_BIT_100M = 868;
    localparam int unsigned DEFAULT_RX_FIFO_DEPTH  = 4;

endpackage

// File: rtl/rx_byte_fifo.sv
// Synchronous byte FIFO with a combinational head read.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   wr_en      : push wr_data; ignored when full unless rd_en pops in the same cycle
//   wr_data    : byte to push
//   rd_en      : pop the head; ignored when empty
//   rd_data    : current head entry (valid while !empty)
//   empty/full : occupancy flags
// Depth must be a power of two, 2 or more.
module rx_byte_fifo #(
    parameter int unsigned Depth = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [7:0]       mem [Depth];
    logic [AddrW-1:0] wr_ptr;
    logic [AddrW-1:0] rd_ptr;
    logic [AddrW:0]   count;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (AddrW + 1)'(Depth));
    assign do_rd   = rd_en && !empty;
    // A pop frees the slot the push lands in, so push is allowed when full.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver feeding the command parser over a valid/ready handshake.
//   clk, rst_n : sys_clk, synchronous active-low reset
//   rx         : asynchronous serial line, idle high
//   out_data   : received byte (LSB first on the wire); out_valid holds until accepted
//   out_ready  : consumer accepts on out_valid & out_ready
//   frame_err  : one-cycle pulse when the stop bit is sampled low
//   overrun    : one-cycle pulse when a completed byte is dropped for lack of room
//   busy       : receiver FSM is not idle
// Build option: define UART_RX_FIFO_EN to replace the single holding register with a
// FIFO_DEPTH-entry FIFO (rx_byte_fifo); otherwise FIFO_DEPTH is not used for storage.
module uart_rx_frame
    import glitcher_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_100M,
    parameter int unsigned FIFO_DEPTH   = DEFAULT_RX_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be in 4..65535");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, 2 or more");
    end

    localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HalfCnt = 16'(CLKS_PER_BIT >> 1);

    rx_state_e   state;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] bit_cnt;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    logic        accept;

    assign accept = out_valid && out_ready;
    assign busy   = (state != StIdle);

    // Preset high so reset does not look like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic       stop_ok;
    logic       fifo_empty;
    logic       fifo_full;
    logic [7:0] fifo_rd_data;

    assign stop_ok   = (state == StStop) && (bit_cnt == LastCnt) && rx_s;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 8'h00 : fifo_rd_data;

    rx_byte_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (stop_ok),
        .wr_data (shreg),
        .rd_en   (accept),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            bit_cnt   <= '0;
            idx       <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifndef UART_RX_FIFO_EN
            out_data  <= '0;
            out_valid <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifndef UART_RX_FIFO_EN
            if (accept) out_valid <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    if (!rx_s) begin
                        state   <= StStart;
                        bit_cnt <= '0;
                    end
                end
                StStart: begin
                    if (bit_cnt == HalfCnt) begin
                        bit_cnt <= '0;
                        idx     <= '0;
                        state   <= rx_s ? StIdle : StData;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                StData: begin
                    if (bit_cnt == LastCnt) begin
                        bit_cnt <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        idx     <= idx + 3'd1;
                        if (idx == 3'd7) state <= StStop;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                StStop: begin
                    if (bit_cnt == LastCnt) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            state <= StIdle;
`ifdef UART_RX_FIFO_EN
                            overrun <= fifo_full && !accept;
`else
                            if (!out_valid || out_ready) begin
                                out_data  <= shreg;
                                out_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
`endif
                        end else begin
                            frame_err <= 1'b1;
                            state     <= StWaitIdle;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                StWaitIdle: begin
                    if (rx_s) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_frame #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         fe_seen = 0, ov_seen = 0, fe_exp = 0, ov_exp = 0;
    bit         rand_ready = 0;
    bit         ready_level = 1;
    bit         hold_prev = 0;
    logic [7:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the DUT buffers up to CAP unaccepted bytes; a byte finishing when the
    // buffer is full is dropped and counted as an overrun.
    task automatic expect_byte(input logic [7:0] b);
        if (exp_q.size() < CAP) exp_q.push_back(b);
        else ov_exp++;
    endtask

    task automatic wait_bit();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bit();
        end
        rx = stop;
        wait_bit();
    endtask

    task automatic send_byte(input logic [7:0] b);
        expect_byte(b);
        send_frame(b, 1'b1);
        idle(4);
    endtask

    task automatic drain(input string name);
        int n;
        for (n = 0; n < 400; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // out_ready driver: fixed level or random per cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
        end
    end

    // Monitor: pops the scoreboard on every accepted byte, counts flag pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (frame_err) fe_seen++;
                if (overrun) ov_seen++;
                if (hold_prev && out_valid) check("out_data_stable", 32'(out_data), 32'(prev_data));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_byte: got 0x%0h, expected no transfer (t=%0t)",
                                 out_data, $time);
                    end else begin
                        check("rx_byte", 32'(out_data), 32'(exp_q.pop_front()));
                    end
                end
                hold_prev = out_valid && !out_ready;
                prev_data = out_data;
            end else begin
                hold_prev = 0;
            end
        end
    end

    initial begin
        int lat;
        int n;
        logic [7:0] b;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({frame_err, overrun}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);

        // 1: 0xA5 with out_ready=1; valid appears inside the stop bit and lasts one cycle
        lat = 0;
        fork
            send_byte(8'hA5);
            begin
                for (lat = 0; lat < 400; lat++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                @(negedge clk);
                check("t1_valid_one_cycle", 32'(out_valid), 32'd0);
            end
        join
        check("t1_valid_in_stop_bit", 32'(lat >= 9 * CPB + HALF && lat <= 10 * CPB), 32'd1);
        check("t1_no_flags", 32'(fe_seen + ov_seen), 32'd0);

        // 2: 5-cycle low glitch is rejected
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        for (n = 0; n < 10; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("t2_busy_clears", 32'(busy), 32'd0);
        idle(30);
        check("t2_no_frame_err", 32'(fe_seen), 32'd0);

        // 3: bad stop bit then long break -> exactly one frame_err; line recovers
        send_frame(8'h3C, 1'b0);
        fe_exp++;
        rx = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        idle(20);
        check("t3_one_frame_err", 32'(fe_seen), 32'(fe_exp));
        send_byte(8'h55);
        drain("t3_drain");

        // 4: consumer stalled, two bytes
        ready_level = 0;
        idle(2);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(20);
        check("t4_valid_held", 32'(out_valid), 32'd1);
        check("t4_head_byte", 32'(out_data), 32'h11);
        check("t4_overrun_count", 32'(ov_seen), 32'(ov_exp));
        ready_level = 1;
        drain("t4_drain");

`ifdef UART_RX_FIFO_EN
        // 5: fill the FIFO past capacity
        ready_level = 0;
        idle(2);
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        idle(20);
        check("t5_overrun_count", 32'(ov_seen), 32'(ov_exp));
        ready_level = 1;
        drain("t5_drain");
`endif

        // 6: reset in the middle of the data bits of 0x7E
        b = 8'h7E;
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            wait_bit();
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        check("t6_busy_after_rst", 32'(busy), 32'd0);
        check("t6_outputs_after_rst", 32'({out_valid, frame_err, overrun, out_data}), 32'd0);
        idle(20 + CPB * 8);
        send_byte(8'h81);
        drain("t6_drain");

        // Random bytes, random consumer back-pressure
        rand_ready = 1;
        for (int i = 0; i < 12; i++) begin
            send_byte(8'($urandom));
            idle($urandom_range(0, 30));
            drain("rand_drain");
        end
        rand_ready = 0;
        ready_level = 1;
        idle(10);

        check("final_frame_err_count", 32'(fe_seen), 32'(fe_exp));
        check("final_overrun_count", 32'(ov_seen), 32'(ov_exp));
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
